// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer_irq block: register window offsets,
// TCON bit positions, the default base address and an address-match helper.
// Optional feature macro used by this block: TIMER_PRESCALE_EN.
package timer_irq_pkg;

    // Default byte address of TH; TL, TCON and PSC follow at +4, +8, +12.
    localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h4000_0000;

    // Register byte offsets within the window.
    localparam logic [31:0] TH_OFS   = 32'd0;
    localparam logic [31:0] TL_OFS   = 32'd4;
    localparam logic [31:0] TCON_OFS = 32'd8;
    localparam logic [31:0] PSC_OFS  = 32'd12;

    // TCON bit indices.
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Counter value at which the next tick reloads from TH.
    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // True when a byte address selects the word at base + ofs; the byte
    // lane bits [1:0] are ignored.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] ofs);
        logic [31:0] target;
        target = base + ofs;
        return addr[31:2] == target[31:2];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler for timer_irq: counts 0..psc_i while enabled and emits a
// one-cycle tick when the count equals psc_i, then wraps to 0.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [7:0] psc_i,
    output logic       tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Terminal count of an enabled prescaler produces the tick.
    assign tick_o = enable_i && (cnt_q == psc_i);

    // Next count: wrap on tick; held at 0 while disabled or on a PSC write.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!enable_i || clear_i || tick_o) begin
            cnt_d = 8'd0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped 32-bit reload timer that drives the IRQ input of the
// pipeline control decoder. Registers: TH (reload), TL (counter),
// TCON {status, int enable, enable} and, with TIMER_PRESCALE_EN defined,
// an 8-bit PSC prescaler register at BASE+12.
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        kernel,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;

    logic sel_th, sel_tl, sel_tcon, sel_psc;
    logic tick;
    logic overflow;

    // Byte-lane bits carry no meaning for word registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Address[1:0];

    assign sel_th   = addr_hit(Address, BASE_ADDR, TH_OFS);
    assign sel_tl   = addr_hit(Address, BASE_ADDR, TL_OFS);
    assign sel_tcon = addr_hit(Address, BASE_ADDR, TCON_OFS);
    assign sel_psc  = addr_hit(Address, BASE_ADDR, PSC_OFS);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psc_q, psc_d;

    // PSC register: loaded by stores to BASE+12.
    always_comb begin
        psc_d = psc_q;
        if (MemWr && sel_psc) begin
            psc_d = WriteData[7:0];
        end
    end

    // PSC state.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= 8'd0;
        end else begin
            psc_q <= psc_d;
        end
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable_i (tcon_q[TCON_EN]),
        .clear_i  (MemWr && sel_psc),
        .psc_i    (psc_q),
        .tick_o   (tick)
    );
`else
    // Without a prescaler every enabled cycle is a tick.
    assign tick = tcon_q[TCON_EN];
`endif

    assign overflow = tick && (tl_q == TL_MAX);

    // Next register state: stores take priority over counting, except that
    // an overflow setting the status bit beats a TCON store clearing it.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (tick) begin
            tl_d = overflow ? th_q : tl_q + 32'd1;
        end

        if (MemWr && sel_th) begin
            th_d = WriteData;
        end
        if (MemWr && sel_tl) begin
            tl_d = WriteData;
        end
        if (MemWr && sel_tcon) begin
            tcon_d = WriteData[2:0];
        end

        if (overflow && tcon_q[TCON_IE]) begin
            tcon_d[TCON_IS] = 1'b1;
        end
    end

    // Timer register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= 32'd0;
            tl_q   <= 32'd0;
            tcon_q <= 3'b000;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    // Combinational load path; zero unless a load hits the window.
    always_comb begin
        ReadData = 32'd0;
        if (MemRd) begin
            if (sel_th) begin
                ReadData = th_q;
            end else if (sel_tl) begin
                ReadData = tl_q;
            end else if (sel_tcon) begin
                ReadData = {29'd0, tcon_q};
            end else if (sel_psc) begin
`ifdef TIMER_PRESCALE_EN
                ReadData = {24'd0, psc_q};
`else
                ReadData = 32'd0;
`endif
            end
        end
    end

    // Level interrupt, masked by the interrupt enable and kernel mode.
    assign IRQ = tcon_q[TCON_IS] & tcon_q[TCON_IE] & ~kernel;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios followed by random
// bus traffic, checked against a register-level reference model. The
// expected {IRQ, ReadData} of each cycle is queued by the driver and popped
// by an independent monitor on the falling edge.
module tb_timer_irq;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRd;
    logic        MemWr;
    logic        kernel;
    logic [31:0] ReadData;
    logic        IRQ;

    timer_irq #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .kernel    (kernel),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_th;
    logic [31:0] m_tl;
    logic        m_en, m_ie, m_is;
    logic [7:0]  m_psc;
    int          m_pc;

    // Scoreboard
    logic [32:0] exp_q[$];
    string       tag_q[$];
    int          vectors;
    int          miscompares;

    // Register index selected by an address: 0..3 in window, -1 otherwise.
    function automatic int reg_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < 32'd16) return int'(off / 4);
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        if (!rd) return 32'd0;
        case (reg_index(a))
            0: return m_th;
            1: return m_tl;
            2: return {29'd0, m_is, m_ie, m_en};
`ifdef TIMER_PRESCALE_EN
            3: return {24'd0, m_psc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_is = 0; m_psc = 0; m_pc = 0;
    endtask

    // One clock edge of the timer as described by its register rules.
    task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic tick, ovf;
        int   idx;
        idx = wr ? reg_index(a) : -1;
`ifdef TIMER_PRESCALE_EN
        tick = m_en && (m_pc == int'(m_psc));
        if (idx == 3 || !m_en || tick) m_pc = 0;
        else m_pc = m_pc + 1;
`else
        tick = m_en;
`endif
        ovf = tick && (m_tl == 32'hFFFF_FFFF);
        if (idx == 1) m_tl = d;
        else if (ovf) m_tl = m_th;
        else if (tick) m_tl = m_tl + 1;
        if (ovf && m_ie) begin
            if (idx == 2) begin m_en = d[0]; m_ie = d[1]; end
            m_is = 1'b1;
        end else if (idx == 2) begin
            m_en = d[0]; m_ie = d[1]; m_is = d[2];
        end
        if (idx == 0) m_th = d;
`ifdef TIMER_PRESCALE_EN
        if (idx == 3) m_psc = d[7:0];
`endif
    endtask

    // Driver: apply one cycle of bus inputs (called at posedge+1).
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic k, input string tag);
        MemRd = rd; MemWr = wr; Address = a; WriteData = d; kernel = k;
        exp_q.push_back({m_is & m_ie & ~k, model_read(rd, a)});
        tag_q.push_back(tag);
        @(posedge clk);
        model_step(wr, a, d);
        #1;
    endtask

    task automatic rd_reg(input int idx, input string tag);
        drive(1'b1, 1'b0, BASE + 32'(idx * 4), 32'd0, 1'b0, tag);
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d, input string tag);
        drive(1'b0, 1'b1, BASE + 32'(idx * 4), d, 1'b0, tag);
    endtask

    task automatic pulse_reset();
        reset = 1'b1; MemRd = 0; MemWr = 0; kernel = 0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare the DUT's outputs each cycle against the queue.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            logic [32:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            if ({IRQ, ReadData} !== e) begin
                miscompares++;
                $display("FAIL %s: got irq=%b rdata=%h, expected irq=%b rdata=%h",
                         t, IRQ, ReadData, e[32], e[31:0]);
            end
        end
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; Address = 0; WriteData = 0; MemRd = 0; MemWr = 0; kernel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        for (int i = 0; i < 4; i++) rd_reg(i, "reset_read");

        // Reload across overflow
        wr_reg(0, 32'hFFFF_FFF0, "wr_th");
        wr_reg(1, 32'hFFFF_FFFE, "wr_tl");
        wr_reg(2, 32'h3, "wr_tcon");
        rd_reg(1, "tl_max");
        rd_reg(1, "tl_reload");
        rd_reg(2, "tcon_pending");
        for (int i = 0; i < 3; i++) rd_reg(1, "tl_after_reload");

        // Clear racing an overflow: the overflow wins
        wr_reg(1, 32'hFFFF_FFFF, "wr_tl_max");
        wr_reg(2, 32'h3, "clear_vs_ovf");
        rd_reg(2, "tcon_after_race");

        // Kernel mode masks IRQ
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, BASE + 32'd8, 32'd0, 1'b1, "kernel_mask");
        rd_reg(2, "kernel_dropped");
        wr_reg(2, 32'h3, "irq_clear");
        rd_reg(2, "irq_cleared");

        // TL store beats a tick
        wr_reg(1, 32'h1234_0000, "wr_tl_vs_tick");
        rd_reg(1, "tl_store_wins");

        // Prescaler (ignored when compiled out)
        wr_reg(2, 32'h0, "stop");
        wr_reg(3, 32'h3, "wr_psc");
        wr_reg(1, 32'h0, "tl_zero");
        wr_reg(2, 32'h1, "start");
        for (int i = 0; i < 10; i++) rd_reg(1, "prescaled_count");
        rd_reg(3, "psc_read");

        // Reset while IRQ is high
        wr_reg(2, 32'h7, "force_irq");
        rd_reg(2, "irq_high");
        pulse_reset();
        rd_reg(2, "after_reset");

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            int          op, idx;
            logic [31:0] a, d;
            logic        k, rd;
            op = $urandom_range(0, 9);
            idx = $urandom_range(0, 5);
            k = ($urandom_range(0, 3) == 0);
            if (idx == 5) a = $urandom;
            else a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            case (idx)
                1: d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
                2: d = {$urandom_range(0, 536870911), 3'($urandom_range(0, 7))};
                3: d = {24'($urandom), 8'($urandom_range(0, 3))};
                default: d = $urandom;
            endcase
            rd = ($urandom_range(0, 1) == 1);
            if (op < 4) drive(1'b1, 1'b0, a, d, k, "rand_load");
            else if (op < 7) drive(rd, 1'b1, a, d, k, "rand_store");
            else drive(1'b0, 1'b0, a, d, k, "rand_idle");
        end

        MemRd = 0; MemWr = 0; kernel = 0;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped 32-bit reload timer that produces the `IRQ` input consumed by the pipeline control decoder. The control decoder turns `IRQ` into the interrupt PC source, `$k0` write and exception return-address capture; this block is the interrupt source.
- Sits on the peripheral bus beside data memory.
- Decodes loads/stores to its register window.
- Raises `IRQ` on counter overflow until software clears the status bit.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: byte address of TH; TL at +4, TCON at +8, PSC at +12.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `Address` in 32: byte address from the EX/MEM ALU result; bits [1:0] ignored.
- `WriteData` in 32: store data.
- `MemRd` in 1: load strobe.
- `MemWr` in 1: store strobe.
- `kernel` in 1: PC[31] of the instruction in decode; masks `IRQ` while in kernel mode.
- `ReadData` out 32: combinational read data; 0 when not a load to this window.
- `IRQ` out 1: interrupt request to the control decoder.

## Operation
- Registers:
  - TH[31:0]: reload value.
  - TL[31:0]: counter.
  - TCON[2:0]: bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status.
- Reset: TH = 0, TL = 0, TCON = 3'b000, prescaler count = 0, PSC = 0. Consequently `IRQ` = 0 and `ReadData` = 0.
- Tick: asserted in a cycle when TCON[0] = 1. With the prescaler compiled in, the condition is additionally that the prescaler is at terminal count.
- Tick with TL ≠ 32'hFFFF_FFFF: TL <= TL + 1.
- Tick with TL = 32'hFFFF_FFFF (overflow):
  - TL <= TH.
  - If TCON[1] = 1, then TCON[2] <= 1.
  - Arithmetic is 32-bit unsigned; no carry out is kept.
- Stores apply when `MemWr` = 1 and `Address[31:2]` matches the window:
  - TH: TH <= `WriteData`.
  - TL: TL <= `WriteData`; this overrides a tick in the same cycle.
  - TCON: TCON[1:0] <= `WriteData[1:0]`; TCON[2] <= `WriteData[2]`, except that an overflow in the same cycle that sets TCON[2] wins, so no interrupt is lost.
- Loads (`MemRd` = 1 and address in window):
  - `ReadData` = TH, TL, or {29'b0, TCON} for the three timer registers.
  - PSC reads as {24'b0, PSC}, or 0 if the prescaler is compiled out.
  - Any other address, or `MemRd` = 0, gives `ReadData` = 0.
- `IRQ` = TCON[2] & TCON[1] & ~`kernel`. It is purely a function of registers plus `kernel`.
- Clearing:
  - Software clears the interrupt by writing TCON with bit2 = 0.
  - Writing bit1 = 0 masks `IRQ` immediately but keeps TCON[2] pending.
- `MemRd` and `MemWr` both high: the store executes; `ReadData` shows pre-write values.

## Timing
- Store: visible on `ReadData` in the cycle after the edge that executes it.
- Overflow tick in cycle N: TL = TH and TCON[2] = 1 from cycle N+1; `IRQ` high in N+1 if unmasked.
- Load latency: 0 cycles (combinational), matching the data memory read path.
- TCON[0] cleared: counting stops at the next edge; TL holds its value; the prescaler count is forced to 0.
- `reset` mid-count or with `IRQ` high: all state returns to reset values at that edge; `IRQ` is 0 the following cycle.
- `IRQ` is level, not pulse: it stays high across cycles until cleared or masked.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PSC[7:0] register at BASE+12.
  - An 8-bit prescaler counts 0..PSC while enabled; a tick occurs in the cycle the count equals PSC, then the count wraps to 0.
  - PSC = 0 gives a tick every enabled cycle.
  - Writing PSC resets the prescaler count to 0.
- `TIMER_PRESCALE_EN` undefined:
  - No PSC storage; a tick occurs every enabled cycle.
  - Stores to BASE+12 are ignored; loads from it return 0.

## Structure
- Shared package holds:
  - Register offsets TH_OFS = 0, TL_OFS = 4, TCON_OFS = 8, PSC_OFS = 12.
  - TCON bit indices TCON_EN = 0, TCON_IE = 1, TCON_IS = 2.
  - Default BASE_ADDR.
- One sub-module, `timer_prescaler`: inputs `clk`, `reset`, enable, clear and PSC; output tick. It is instantiated only under `TIMER_PRESCALE_EN`.

## Test plan
- Reset, then load TH/TL/TCON/PSC → all read 0; `IRQ` = 0.
- Reload:
  - Stimulus: TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFE, TCON = 3'b011.
  - Expected: TL reads FFFF_FFFF after 1 cycle; TL = FFFF_FFF0 and `IRQ` = 1 after 2 cycles.
  - Then TL increments by 1 per cycle.
- Clear versus overflow: write TCON = 3'b011 in the same cycle as an overflow → TCON reads 3'b111; `IRQ` stays 1.
- Kernel mask:
  - Stimulus: with TCON[2] = 1, raise `kernel` for 3 cycles.
  - Expected: `IRQ` = 0 throughout, then 1 after `kernel` drops.
  - Then write TCON = 3'b011 → `IRQ` = 0 next cycle.
- TL write against tick: write TL = 32'h1234_0000 while enabled → TL reads 1234_0000 next cycle, not 1234_0001.
- With `TIMER_PRESCALE_EN`, PSC = 3, TCON = 3'b001 → TL increments once every 4 cycles. Without it, a PSC write is ignored and TL increments every cycle.
